// File: rtl/maxpool_layer_if.sv
// Pixel-stream bundle for the 2x2 max-pool stage: upstream pixel input plus pooled output.
// The slave modport is the pooling block's view; master is the surrounding datapath's view.
interface maxpool_layer_if #(
    parameter int INPUT_CHANNELS = 3,
    parameter int PX_SIZE        = 8
);
    logic                                     in_valid;
    logic                                     in_ready;
    logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0]   in_px;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0]   out_px;
    logic                                     out_last;

    modport slave (
        input  in_valid,
        input  in_px,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_px,
        output out_last
    );

    modport master (
        output in_valid,
        output in_px,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_px,
        input  out_last
    );
endinterface

// File: rtl/maxpool_layer.sv
// Streaming 2x2 stride-2 max pool over raster-order pixels, all channels in parallel.
// Latency: pooled pixel valid one cycle after the window's bottom-right input transfer.
// Backpressure: in_ready = !out_valid || out_ready; a held output freezes all pooling state.
module maxpool_layer #(
    parameter int INPUT_SIZE     = 8,
    parameter int INPUT_CHANNELS = 3,
    parameter int PX_SIZE        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    maxpool_layer_if.slave  bus
);
    localparam int OUTPUT_SIZE = INPUT_SIZE / 2;
    localparam int CW          = $clog2(INPUT_SIZE);
    localparam int LW          = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam bit ODD_SIZE    = (INPUT_SIZE % 2) != 0;

    localparam logic [CW-1:0] LAST_IDX = CW'(INPUT_SIZE - 1);
    localparam logic [CW-1:0] WIN_END  = CW'(2 * OUTPUT_SIZE - 1);

    typedef logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0] px_t;

    function automatic px_t px_max(input px_t a, input px_t b);
        px_t m;
        for (int c = 0; c < INPUT_CHANNELS; c++) begin
            m[c] = (a[c] >= b[c]) ? a[c] : b[c];
        end
        return m;
    endfunction

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    px_t           partial_q, partial_d;
    px_t           line_q [OUTPUT_SIZE];
    px_t           line_d [OUTPUT_SIZE];
    logic          out_valid_q, out_valid_d;
    px_t           out_px_q, out_px_d;
    logic          out_last_q, out_last_d;

    logic          in_ready;
    logic          in_xfer;
    logic          in_window;
    logic [LW-1:0] col_idx;
    px_t           in_px;
    px_t           hmax;
    px_t           pooled;

    assign in_ready      = !out_valid_q || bus.out_ready;
    assign in_xfer       = bus.in_valid && in_ready;
    assign in_px         = bus.in_px;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_px    = out_px_q;
    assign bus.out_last  = out_last_q;

    // With an odd frame size the last column and last row fall outside every window.
    assign in_window = !ODD_SIZE || ((x_q != LAST_IDX) && (y_q != LAST_IDX));
    assign col_idx   = LW'(x_q >> 1);
    assign hmax      = px_max(partial_q, in_px);
    assign pooled    = px_max(line_q[col_idx], hmax);

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        partial_d   = partial_q;
        line_d      = line_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_px_d    = out_px_q;
        out_last_d  = out_last_q;

        if (in_xfer) begin
            if (x_q == LAST_IDX) begin
                x_d = '0;
                y_d = (y_q == LAST_IDX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end

            if (in_window) begin
                if (!x_q[0]) begin
                    partial_d = in_px;
                end else if (!y_q[0]) begin
                    line_d[col_idx] = hmax;
                end else begin
                    // A load here only happens when the register is empty or draining.
                    out_valid_d = 1'b1;
                    out_px_d    = pooled;
                    out_last_d  = (x_q == WIN_END) && (y_q == WIN_END);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            y_q         <= '0;
            partial_q   <= '0;
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                line_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_px_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            partial_q   <= partial_d;
            line_q      <= line_d;
            out_valid_q <= out_valid_d;
            out_px_q    <= out_px_d;
            out_last_q  <= out_last_d;
        end
    end
endmodule

// File: tb/tb_maxpool_layer.sv
// Directed bench for maxpool_layer: a 4x4x3 instance and a 5x5x1 instance on one clock.
// Beats come from vector tables with hand-computed pooled results; stall and reset are hand sequences.
module tb_maxpool_layer;
    typedef struct {
        logic [23:0] px;
        logic        exp_vld;
        logic [23:0] exp_px;
        logic        exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    maxpool_layer_if #(.INPUT_CHANNELS(3), .PX_SIZE(8)) b4 ();
    maxpool_layer_if #(.INPUT_CHANNELS(1), .PX_SIZE(8)) b5 ();

    maxpool_layer #(.INPUT_SIZE(4), .INPUT_CHANNELS(3), .PX_SIZE(8)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    maxpool_layer #(.INPUT_SIZE(5), .INPUT_CHANNELS(1), .PX_SIZE(8)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b5)
    );

    int   checks = 0;
    int   errors = 0;
    vec_t tab_a [16];
    vec_t tab_b [16];
    vec_t tab5  [25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic beat4(input string tag, input int idx, input vec_t v);
        b4.in_valid = 1'b1;
        b4.in_px    = v.px;
        #1;
        check($sformatf("%s[%0d] in_ready", tag, idx), 32'(b4.in_ready), 32'd1);
        @(posedge clk);
        #1;
        check($sformatf("%s[%0d] out_valid", tag, idx), 32'(b4.out_valid), 32'(v.exp_vld));
        if (v.exp_vld) begin
            check($sformatf("%s[%0d] out_px", tag, idx), 32'(b4.out_px), 32'(v.exp_px));
            check($sformatf("%s[%0d] out_last", tag, idx), 32'(b4.out_last), 32'(v.exp_last));
        end
    endtask

    initial begin
        int i;
        int v;
        int n_out;

        // Frame A: ch0 = 1..16, ch1 = 0x7F with 0x80 at (0,0) and (3,2), ch2 = 255 - ch0.
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                i = 4 * y + x;
                v = i + 1;
                tab_a[i].px       = {8'(255 - v),
                                     (((x == 0) && (y == 0)) || ((x == 3) && (y == 2))) ? 8'h80 : 8'h7F,
                                     8'(v)};
                tab_a[i].exp_vld  = 1'b0;
                tab_a[i].exp_px   = '0;
                tab_a[i].exp_last = 1'b0;
            end
        end
        tab_a[5]  = '{tab_a[5].px,  1'b1, 24'hFE_80_06, 1'b0};
        tab_a[7]  = '{tab_a[7].px,  1'b1, 24'hFC_7F_08, 1'b0};
        tab_a[13] = '{tab_a[13].px, 1'b1, 24'hF6_7F_0E, 1'b0};
        tab_a[15] = '{tab_a[15].px, 1'b1, 24'hF4_80_10, 1'b1};

        // Frame B: channel c = x+y+7c, with pixel (2,0) ch2 forced to 255.
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                i = 4 * y + x;
                tab_b[i].px       = {8'(x + y + 14), 8'(x + y + 7), 8'(x + y)};
                tab_b[i].exp_vld  = 1'b0;
                tab_b[i].exp_px   = '0;
                tab_b[i].exp_last = 1'b0;
            end
        end
        tab_b[2].px[23:16] = 8'hFF;
        tab_b[5]  = '{tab_b[5].px,  1'b1, 24'h10_09_02, 1'b0};
        tab_b[7]  = '{tab_b[7].px,  1'b1, 24'hFF_0B_04, 1'b0};
        tab_b[13] = '{tab_b[13].px, 1'b1, 24'h12_0B_04, 1'b0};
        tab_b[15] = '{tab_b[15].px, 1'b1, 24'h14_0D_06, 1'b1};

        // 5x5 frame: value 10*y+x; only the top-left 4x4 region pools.
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                i = 5 * y + x;
                tab5[i].px       = 24'(10 * y + x);
                tab5[i].exp_vld  = 1'b0;
                tab5[i].exp_px   = '0;
                tab5[i].exp_last = 1'b0;
            end
        end
        tab5[6]  = '{tab5[6].px,  1'b1, 24'd11, 1'b0};
        tab5[8]  = '{tab5[8].px,  1'b1, 24'd13, 1'b0};
        tab5[16] = '{tab5[16].px, 1'b1, 24'd31, 1'b0};
        tab5[18] = '{tab5[18].px, 1'b1, 24'd33, 1'b1};

        rst_n        = 1'b0;
        b4.in_valid  = 1'b0;
        b4.in_px     = '0;
        b4.out_ready = 1'b1;
        b5.in_valid  = 1'b0;
        b5.in_px     = '0;
        b5.out_ready = 1'b1;

        #12;
        check("rst out_valid", 32'(b4.out_valid), 32'd0);
        check("rst out_px", 32'(b4.out_px), 32'd0);
        check("rst out_last", 32'(b4.out_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst in_ready4", 32'(b4.in_ready), 32'd1);
        check("post-rst in_ready5", 32'(b5.in_ready), 32'd1);
        check("post-rst out_valid5", 32'(b5.out_valid), 32'd0);

        // Odd-sized frame: edge column/row accepted and dropped.
        n_out = 0;
        for (int k = 0; k < 25; k++) begin
            b5.in_valid = 1'b1;
            b5.in_px    = tab5[k].px[7:0];
            #1;
            check($sformatf("odd[%0d] in_ready", k), 32'(b5.in_ready), 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("odd[%0d] out_valid", k), 32'(b5.out_valid), 32'(tab5[k].exp_vld));
            if (b5.out_valid) n_out++;
            if (tab5[k].exp_vld) begin
                check($sformatf("odd[%0d] out_px", k), 32'(b5.out_px), 32'(tab5[k].exp_px[7:0]));
                check($sformatf("odd[%0d] out_last", k), 32'(b5.out_last), 32'(tab5[k].exp_last));
            end
        end
        b5.in_valid = 1'b0;
        check("odd output count", 32'(n_out), 32'd4);

        // Two frames back to back with in_valid held high.
        for (int k = 0; k < 16; k++) beat4("frmA", k, tab_a[k]);
        for (int k = 0; k < 16; k++) beat4("frmB", k, tab_b[k]);

        // Stall the first pooled pixel for 5 cycles with the next pixel offered.
        for (int k = 0; k < 6; k++) beat4("bp", k, tab_a[k]);
        b4.out_ready = 1'b0;
        b4.in_valid  = 1'b1;
        b4.in_px     = tab_a[6].px;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp stall%0d in_ready", k), 32'(b4.in_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("bp stall%0d out_valid", k), 32'(b4.out_valid), 32'd1);
            check($sformatf("bp stall%0d out_px", k), 32'(b4.out_px), 32'h00FE8006);
            check($sformatf("bp stall%0d out_last", k), 32'(b4.out_last), 32'd0);
        end
        b4.out_ready = 1'b1;
        for (int k = 6; k < 16; k++) beat4("bp", k, tab_a[k]);

        // Reset with a pooled pixel pending after 6 transfers, then a fresh frame.
        for (int k = 0; k < 6; k++) beat4("mid", k, tab_b[k]);
        b4.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-rst out_valid", 32'(b4.out_valid), 32'd0);
        check("mid-rst out_px", 32'(b4.out_px), 32'd0);
        check("mid-rst in_ready", 32'(b4.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) beat4("fresh", k, tab_a[k]);
        b4.in_valid = 1'b0;

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
